cache_ctrl_2way: RTL and testbench

//  Blocking write-back, write-allocate controller for the 2-way set-associative data cache array.

---
 rtl/cache_ctrl_2way_pkg.sv | 39 +++
 rtl/cache_ctrl_2way_lru_table.sv | 34 +++
 rtl/cache_ctrl_2way.sv | 199 +++++++++++++++++++
 tb/tb_cache_ctrl_2way.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_2way_pkg.sv
// Shared definitions for the 2-way write-back data cache controller:
// geometry constants, FSM state encoding and CPU address field slicing.
// Byte address layout: {tag, index, word[1:0], byte[1:0]}.
package cache_ctrl_2way_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int INDEX_BITS     = 5;
    localparam int TAG_BITS       = ADDR_WIDTH - INDEX_BITS - 4;
    localparam int LINE_WIDTH     = 128;
    localparam int WORD_WIDTH     = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int NUM_SETS       = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_REFILL    = 2'd3
    } state_t;

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1 -: TAG_BITS];
    endfunction

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return a[4 +: INDEX_BITS];
    endfunction

    function automatic logic [1:0] addr_word(input logic [ADDR_WIDTH-1:0] a);
        return a[3:2];
    endfunction

    // Pick one 32-bit word out of a line; word 0 sits in the low bits.
    function automatic logic [WORD_WIDTH-1:0] line_word(input logic [LINE_WIDTH-1:0] line,
                                                        input logic [1:0]            w);
        return line[{w, 5'b00000} +: WORD_WIDTH];
    endfunction

endpackage

// File: rtl/cache_ctrl_2way_lru_table.sv
// lru_table_2way: one LRU bit per set. The stored bit names the least
// recently used way, i.e. the replacement candidate when both ways are valid.
// Ports:
//   clk, rst       clock, synchronous active-high reset (all bits -> 0)
//   rd_index       set being looked up
//   rd_lru         LRU way of rd_index (combinational)
//   wr_en          update strobe
//   wr_index       set to update
//   wr_mru_way     way just used; the other way becomes LRU
module lru_table_2way
    import cache_ctrl_2way_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_lru,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_mru_way
);

    logic [NUM_SETS-1:0] lru_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            lru_bits <= '0;
        end else if (wr_en) begin
            lru_bits[wr_index] <= ~wr_mru_way;
        end
    end

    assign rd_lru = lru_bits[rd_index];

endmodule

// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way: blocking write-back / write-allocate controller for a
// 2-way set-associative data cache array with a 128-bit line memory port.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/byte_en    CPU request, held stable until cpu_ready
//   cpu_rdata, cpu_ready             load data and one-cycle completion pulse
//   arr_addr, arr_tag                set index / tag of the latched request
//   arr_wr_en, arr_refill, arr_way_select, arr_wr_data,
//   arr_wr_word_en, arr_wr_byte_en   array write controls
//   arr_valid/hit/modify/tags/rd_data  combinational array lookup results
//   mem_req/we/addr/wdata            line fetch / writeback request
//   mem_rdata, mem_ack               fetched line and one-cycle completion pulse
//   dbg_state                        current FSM state (state_t encoding)
//
// Handshakes: the CPU raises cpu_req with stable fields and keeps them until
// it sees cpu_ready for exactly one cycle; a request is only taken in IDLE.
// mem_req with stable mem_we/addr/wdata is held until a one-cycle mem_ack;
// mem_ack is only looked at while mem_req is high, and a writeback ack leads
// straight into the refill request.
module cache_ctrl_2way
    import cache_ctrl_2way_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [31:0]             cpu_wdata,
    input  logic [3:0]              cpu_byte_en,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_ready,
    output logic [INDEX_BITS-1:0]   arr_addr,
    output logic [TAG_BITS-1:0]     arr_tag,
    output logic                    arr_wr_en,
    output logic                    arr_refill,
    output logic [1:0]              arr_way_select,
    output logic [LINE_WIDTH-1:0]   arr_wr_data,
    output logic [3:0]              arr_wr_word_en,
    output logic [3:0]              arr_wr_byte_en,
    input  logic [1:0]              arr_valid,
    input  logic [1:0]              arr_hit,
    input  logic [1:0]              arr_modify,
    input  logic [2*TAG_BITS-1:0]   arr_tags,
    input  logic [2*LINE_WIDTH-1:0] arr_rd_data,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [LINE_WIDTH-1:0]   mem_wdata,
    input  logic [LINE_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack,
    output logic [1:0]              dbg_state
);

    state_t                state_q, state_d;
    logic [TAG_BITS-1:0]   req_tag_q;
    logic [INDEX_BITS-1:0] req_index_q;
    logic [1:0]            req_word_q;
    logic                  req_we_q;
    logic [31:0]           req_wdata_q;
    logic [3:0]            req_be_q;
    logic                  victim_q;

    // Byte offset is irrelevant for word-wide accesses.
    logic unused_byte_offset;
    assign unused_byte_offset = &{1'b0, cpu_addr[1:0]};

    logic                  accept;
    logic                  any_hit;
    logic                  hit_way;
    logic [LINE_WIDTH-1:0] hit_line;
    logic                  lru_rd;
    logic                  victim_d;
    logic                  victim_dirty;
    logic [LINE_WIDTH-1:0] victim_line;
    logic [TAG_BITS-1:0]   victim_tag;
    logic                  lru_wr_en;
    logic                  lru_mru_way;

    assign accept  = (state_q == ST_IDLE) && cpu_req;
    assign any_hit = |arr_hit;
    // A double hit can only come from a corrupt array; way0 wins.
    assign hit_way  = ~arr_hit[0];
    assign hit_line = hit_way ? arr_rd_data[LINE_WIDTH +: LINE_WIDTH] : arr_rd_data[0 +: LINE_WIDTH];

    // Fill an empty way before evicting anything; only then consult LRU.
    assign victim_d     = !arr_valid[0] ? 1'b0 : (!arr_valid[1] ? 1'b1 : lru_rd);
    assign victim_dirty = arr_valid[victim_d] && arr_modify[victim_d];
    assign victim_line  = victim_q ? arr_rd_data[LINE_WIDTH +: LINE_WIDTH] : arr_rd_data[0 +: LINE_WIDTH];
    assign victim_tag   = victim_q ? arr_tags[TAG_BITS +: TAG_BITS] : arr_tags[0 +: TAG_BITS];

    assign arr_addr  = req_index_q;
    assign arr_tag   = req_tag_q;
    assign dbg_state = state_q;

    lru_table_2way u_lru (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (req_index_q),
        .rd_lru     (lru_rd),
        .wr_en      (lru_wr_en),
        .wr_index   (req_index_q),
        .wr_mru_way (lru_mru_way)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_tag_q   <= '0;
            req_index_q <= '0;
            req_word_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            victim_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_tag_q   <= addr_tag(cpu_addr);
                req_index_q <= addr_index(cpu_addr);
                req_word_q  <= addr_word(cpu_addr);
                req_we_q    <= cpu_we;
                req_wdata_q <= cpu_wdata;
                req_be_q    <= cpu_byte_en;
            end
            if (state_q == ST_COMPARE && !any_hit) begin
                victim_q <= victim_d;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cpu_ready      = 1'b0;
        cpu_rdata      = '0;
        arr_wr_en      = 1'b0;
        arr_refill     = 1'b0;
        arr_way_select = '0;
        arr_wr_data    = '0;
        arr_wr_word_en = '0;
        arr_wr_byte_en = '0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        lru_wr_en      = 1'b0;
        lru_mru_way    = 1'b0;
        // While reset is held every output stays quiet, so an interrupted
        // refill can never write the array.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cpu_req) state_d = ST_COMPARE;
                end
                ST_COMPARE: begin
                    if (any_hit) begin
                        cpu_ready   = 1'b1;
                        lru_wr_en   = 1'b1;
                        lru_mru_way = hit_way;
                        if (req_we_q) begin
                            arr_wr_en      = 1'b1;
                            arr_way_select = hit_way ? 2'b10 : 2'b01;
                            arr_wr_data    = {WORDS_PER_LINE{req_wdata_q}};
                            arr_wr_word_en = 4'b0001 << req_word_q;
                            arr_wr_byte_en = req_be_q;
                        end else begin
                            cpu_rdata = line_word(hit_line, req_word_q);
                        end
                        state_d = ST_IDLE;
                    end else begin
                        state_d = victim_dirty ? ST_WRITEBACK : ST_REFILL;
                    end
                end
                ST_WRITEBACK: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {victim_tag, req_index_q, 4'b0000};
                    mem_wdata = victim_line;
                    if (mem_ack) state_d = ST_REFILL;
                end
                ST_REFILL: begin
                    mem_req  = 1'b1;
                    mem_addr = {req_tag_q, req_index_q, 4'b0000};
                    if (mem_ack) begin
                        arr_wr_en      = 1'b1;
                        arr_refill     = 1'b1;
                        arr_way_select = victim_q ? 2'b10 : 2'b01;
                        arr_wr_data    = mem_rdata;
                        arr_wr_word_en = 4'hF;
                        arr_wr_byte_en = 4'hF;
                        // Re-lookup now hits and finishes the access.
                        state_d        = ST_COMPARE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Bench for cache_ctrl_2way: behavioural 2-way array and line memory around
// the controller, directed CPU accesses with hand-computed load data.
module tb_cache_ctrl_2way;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic [3:0]   cpu_byte_en;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic [4:0]   arr_addr;
    logic [22:0]  arr_tag;
    logic         arr_wr_en, arr_refill;
    logic [1:0]   arr_way_select;
    logic [127:0] arr_wr_data;
    logic [3:0]   arr_wr_word_en, arr_wr_byte_en;
    logic [1:0]   arr_valid, arr_hit, arr_modify;
    logic [45:0]  arr_tags;
    logic [255:0] arr_rd_data;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ack, ack_r, stray_ack;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    cache_ctrl_2way dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .arr_addr(arr_addr), .arr_tag(arr_tag), .arr_wr_en(arr_wr_en),
        .arr_refill(arr_refill), .arr_way_select(arr_way_select),
        .arr_wr_data(arr_wr_data), .arr_wr_word_en(arr_wr_word_en),
        .arr_wr_byte_en(arr_wr_byte_en), .arr_valid(arr_valid), .arr_hit(arr_hit),
        .arr_modify(arr_modify), .arr_tags(arr_tags), .arr_rd_data(arr_rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dbg_state(dbg_state)
    );

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural array ----------------
    bit         m_valid [2][32];
    bit         m_mod   [2][32];
    bit [22:0]  m_tag   [2][32];
    bit [127:0] m_data  [2][32];

    function automatic logic [127:0] merge_line(input logic [127:0] old, input logic [127:0] nw,
                                                input logic [3:0] we, input logic [3:0] be);
        logic [127:0] r = old;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 4; b++)
                if (we[k] && be[b]) r[k*32+b*8 +: 8] = nw[k*32+b*8 +: 8];
        return r;
    endfunction

    always_comb begin
        arr_valid = '0; arr_hit = '0; arr_modify = '0; arr_tags = '0; arr_rd_data = '0;
        for (int w = 0; w < 2; w++) begin
            arr_valid[w]            = m_valid[w][arr_addr];
            arr_modify[w]           = m_mod[w][arr_addr];
            arr_hit[w]              = m_valid[w][arr_addr] && (m_tag[w][arr_addr] == arr_tag);
            arr_tags[w*23 +: 23]    = m_tag[w][arr_addr];
            arr_rd_data[w*128 +: 128] = m_data[w][arr_addr];
        end
    end

    always @(posedge clk) begin
        if (arr_wr_en) begin
            for (int w = 0; w < 2; w++) begin
                if (arr_way_select[w]) begin
                    if (arr_refill) begin
                        m_valid[w][arr_addr] <= 1'b1;
                        m_mod[w][arr_addr]   <= 1'b0;
                        m_tag[w][arr_addr]   <= arr_tag;
                        m_data[w][arr_addr]  <= arr_wr_data;
                    end else begin
                        m_mod[w][arr_addr]   <= 1'b1;
                        m_data[w][arr_addr]  <= merge_line(m_data[w][arr_addr], arr_wr_data,
                                                           arr_wr_word_en, arr_wr_byte_en);
                    end
                end
            end
        end
    end

    // ---------------- line memory responder ----------------
    logic [127:0] mem_store [logic [31:0]];
    logic [32:0]  mem_log[$];        // {we, line address} per completed request
    logic [127:0] wb_data_q[$];
    int           mem_delay = 2;
    int           hold_err  = 0;

    // Untouched lines read back as 0x5000_0000 + byte address of each word.
    function automatic logic [127:0] mem_line(input logic [31:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'h5000_0000 + la + 32'(w * 4);
        return l;
    endfunction

    assign mem_ack = ack_r | stray_ack;

    initial begin
        logic         cur_we, aborted;
        logic [31:0]  cur_addr;
        logic [127:0] cur_wdata;
        ack_r = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_req) begin
                cur_we = mem_we; cur_addr = mem_addr; cur_wdata = mem_wdata; aborted = 1'b0;
                for (int i = 0; i < mem_delay; i++) begin
                    @(posedge clk); #1;
                    if (!mem_req) begin aborted = 1'b1; break; end
                    if (mem_we !== cur_we || mem_addr !== cur_addr || mem_wdata !== cur_wdata) hold_err++;
                end
                if (!aborted) begin
                    mem_log.push_back({cur_we, cur_addr});
                    if (cur_we) begin
                        mem_store[cur_addr] = cur_wdata;
                        wb_data_q.push_back(cur_wdata);
                    end else begin
                        mem_rdata = mem_store.exists(cur_addr) ? mem_store[cur_addr] : mem_line(cur_addr);
                    end
                    ack_r = 1'b1;
                    @(posedge clk); #1;
                    ack_r = 1'b0; mem_rdata = '0;
                    // A fetch ends the memory phase; a writeback rolls into the fetch.
                    check("mem_req_after_ack", mem_req, cur_we);
                end
            end
        end
    end

    // ---------------- monitors / scoreboard ----------------
    logic [32:0]  exp_q[$];          // {is_load, expected load data}
    logic [10:0]  wr_log[$];         // {refill, way_select, word_en, byte_en}
    logic [127:0] wr_data_log[$];
    int           mem_req_cycles = 0;

    always @(negedge clk) begin
        if (!rst && cpu_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cpu_ready", 1'b1, 1'b0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if (e[32]) check("cpu_rdata", cpu_rdata, e[31:0]);
            end
        end
        if (arr_wr_en) begin
            wr_log.push_back({arr_refill, arr_way_select, arr_wr_word_en, arr_wr_byte_en});
            wr_data_log.push_back(arr_wr_data);
        end
        if (mem_req) mem_req_cycles++;
    end

    // ---------------- driver ----------------
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] exp_data, input int exp_lat);
        int  cyc  = 0;
        bit  done = 0;
        exp_q.push_back({~we, exp_data});
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_byte_en = be;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cpu_ready) done = 1;
        end
        if (!done) check("cpu_ready_timeout", 1'b0, 1'b1);
        else if (exp_lat != 0) check("hit_latency", 32'(cyc), 32'(exp_lat));
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byte_en = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n_mem, n_wr, c0, w0;
        bit seen;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_byte_en = '0; stray_ack = 1'b0;
        mem_store[32'h0000_1230] = {32'h3333_0003, 32'h2222_0002, 32'hCAFE_F00D, 32'h1111_0000};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {cpu_ready, mem_req, arr_wr_en, arr_addr, arr_tag, mem_addr},
              '0);
        check("reset_state", dbg_state, 2'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: cold load -> refill way0, no writeback
        cpu_access(1'b0, 32'h0000_1234, '0, '0, 32'hCAFE_F00D, 0);
        check("t1_mem_log_size", mem_log.size(), 1);
        check("t1_fetch_addr", mem_log[0], {1'b0, 32'h0000_1230});
        check("t1_refill_ctrl", wr_log[0], {1'b1, 2'b01, 4'hF, 4'hF});

        // 2: store hit, bytes 0-1 of word1
        c0 = mem_req_cycles; n_wr = wr_log.size();
        cpu_access(1'b1, 32'h0000_1234, 32'h0000_BEEF, 4'b0011, '0, 2);
        check("t2_wr_count", wr_log.size() - n_wr, 1);
        check("t2_wr_ctrl", wr_log[n_wr], {1'b0, 2'b01, 4'b0010, 4'b0011});
        check("t2_wr_data", wr_data_log[n_wr], {4{32'h0000_BEEF}});
        check("t2_no_mem", mem_req_cycles - c0, 0);
        cpu_access(1'b0, 32'h0000_1234, '0, '0, 32'hCAFE_BEEF, 2);

        // 3: fill way1 cleanly, then a third tag evicts the dirty 0x1230 line
        cpu_access(1'b0, 32'h0000_2234, '0, '0, 32'h5000_2234, 0);
        check("t3_fill_way1", wr_log[wr_log.size()-1], {1'b1, 2'b10, 4'hF, 4'hF});
        n_mem = mem_log.size();
        mem_delay = 10;
        cpu_access(1'b0, 32'h0000_3234, '0, '0, 32'h5000_3234, 0);
        check("t3_mem_ops", mem_log.size() - n_mem, 2);
        check("t3_wb_addr", mem_log[n_mem], {1'b1, 32'h0000_1230});
        check("t3_wb_word1", wb_data_q[0][63:32], 32'hCAFE_BEEF);
        check("t3_refill_addr", mem_log[n_mem+1], {1'b0, 32'h0000_3230});
        check("t6_req_held", hold_err, 0);

        // 6: stray ack while idle is ignored
        n_wr = wr_log.size();
        @(posedge clk); #1 stray_ack = 1'b1;
        @(posedge clk); #1 stray_ack = 1'b0;
        @(negedge clk);
        check("t6_stray_state", dbg_state, 2'd0);
        check("t6_stray_quiet", {mem_req, cpu_ready, 32'(wr_log.size() - n_wr)}, '0);

        // 4: clean victim (way1, 0x2230) goes straight to refill
        mem_delay = 2; n_mem = mem_log.size();
        cpu_access(1'b0, 32'h0000_4234, '0, '0, 32'h5000_4234, 0);
        check("t4_single_fetch", mem_log.size() - n_mem, 1);
        check("t4_fetch_addr", mem_log[n_mem], {1'b0, 32'h0000_4230});
        check("t4_refill_way1", wr_log[wr_log.size()-1], {1'b1, 2'b10, 4'hF, 4'hF});
        n_mem = mem_log.size();
        cpu_access(1'b0, 32'h0000_3234, '0, '0, 32'h5000_3234, 2);
        check("t4_other_way_hit", mem_log.size() - n_mem, 0);

        // 5: reset during a long refill
        mem_delay = 40; n_wr = wr_log.size();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_5234;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (dbg_state == 2'd3) seen = 1;
        end
        check("t5_reached_refill", seen, 1'b1);
        @(posedge clk); #1 cpu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_state_idle", dbg_state, 2'd0);
        check("t5_mem_req_low", mem_req, 1'b0);
        check("t5_no_wr_en", arr_wr_en, 1'b0);
        @(posedge clk); #1 rst = 1'b0; cpu_addr = '0;
        check("t5_no_array_write", wr_log.size() - n_wr, 0);
        // LRU cleared: set 3 now evicts way0 although way0 was used last
        mem_delay = 2;
        repeat (3) @(posedge clk);
        cpu_access(1'b0, 32'h0000_6234, '0, '0, 32'h5000_6234, 0);
        check("t5_lru_reset_way0", wr_log[wr_log.size()-1], {1'b1, 2'b01, 4'hF, 4'hF});
        cpu_access(1'b0, 32'h0000_4234, '0, '0, 32'h5000_4234, 2);

        repeat (4) @(posedge clk);
        w0 = exp_q.size();
        check("scoreboard_drained", w0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard in case the sequence itself stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
